// File: rtl/bcd_counter_n.sv
// Multi-decade packed-BCD up/down counter with load, clear, programmable
// terminal value and wrap/saturate handling at the range bounds.
module bcd_counter_n #(
  parameter int unsigned          DIGITS   = 2,
  parameter logic [4*DIGITS-1:0]  MAX_VAL  = {DIGITS{4'h9}},
  parameter bit                   SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   ld_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  tc,
  output logic                  wrap,
  output logic                  ld_err
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] cnt_nxt;
  logic         wrap_nxt;
  logic         ld_err_nxt;
  logic         at_max;
  logic         at_zero;
  logic         ld_ok;

  // True when every nibble is a decimal digit.
  function automatic logic is_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Ripple increment: a digit at 9 rolls to 0 and carries upward.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Ripple decrement: a digit at 0 rolls to 9 and borrows upward.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign at_max  = (cnt == MAX_VAL);
  assign at_zero = (cnt == W'(0));
  // Once all nibbles are 0-9, the plain unsigned compare orders values
  // exactly like a most-significant-digit-first decimal compare.
  assign ld_ok   = is_bcd(ld_val) && (ld_val <= MAX_VAL);
  assign tc      = up ? at_max : at_zero;

  // Next-count selection: clr > ld > en.
  always_comb begin
    cnt_nxt    = cnt;
    wrap_nxt   = 1'b0;
    ld_err_nxt = 1'b0;
    if (clr) begin
      cnt_nxt = W'(0);
    end else if (ld) begin
      if (ld_ok) cnt_nxt    = ld_val;
      else       ld_err_nxt = 1'b1;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          wrap_nxt = 1'b1;
          if (!SATURATE) cnt_nxt = W'(0);
        end else begin
          cnt_nxt = bcd_inc(cnt);
        end
      end else begin
        if (at_zero) begin
          wrap_nxt = 1'b1;
          if (!SATURATE) cnt_nxt = MAX_VAL;
        end else begin
          cnt_nxt = bcd_dec(cnt);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= W'(0);
      wrap   <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      wrap   <= wrap_nxt;
      ld_err <= ld_err_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: two configurations (wrap at 99, saturate at 59)
// driven in lockstep and compared against an integer-arithmetic model.
module tb_bcd_counter_n;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       clr;
  logic       ld;
  logic [7:0] ld_val;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
  logic       tc_a, tc_b;
  logic       wrap_a, wrap_b;
  logic       ld_err_a, ld_err_b;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_a, m_b;

  bcd_counter_n u_dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .ld(ld),
    .ld_val(ld_val), .cnt(cnt_a), .tc(tc_a), .wrap(wrap_a), .ld_err(ld_err_a)
  );

  bcd_counter_n #(.DIGITS(2), .MAX_VAL(8'h59), .SATURATE(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .ld(ld),
    .ld_val(ld_val), .cnt(cnt_b), .tc(tc_b), .wrap(wrap_b), .ld_err(ld_err_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else             n_pass++;
  endtask

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic bit valid_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Reference behaviour computed on plain integers.
  function automatic void model_next(input logic [7:0] cur, input logic [7:0] maxv,
                                     input bit sat, output logic [7:0] nc,
                                     output logic nw, output logic ne);
    int c, m;
    c  = bcd2int(cur);
    m  = bcd2int(maxv);
    nc = cur;
    nw = 1'b0;
    ne = 1'b0;
    if (clr) begin
      nc = 8'h00;
    end else if (ld) begin
      if (valid_bcd(ld_val) && bcd2int(ld_val) <= m) nc = ld_val;
      else                                            ne = 1'b1;
    end else if (en) begin
      if (up) begin
        if (c == m) begin nw = 1'b1; nc = sat ? cur : 8'h00; end
        else        nc = int2bcd(c + 1);
      end else begin
        if (c == 0) begin nw = 1'b1; nc = sat ? cur : maxv; end
        else        nc = int2bcd(c - 1);
      end
    end
  endfunction

  task automatic drive(input logic e, input logic u, input logic c, input logic l,
                       input logic [7:0] v);
    en = e; up = u; clr = c; ld = l; ld_val = v;
  endtask

  // One clock edge: advance both models, then compare every output.
  task automatic tick();
    logic [7:0] na, nb;
    logic       wa, wb, ea, eb;
    model_next(m_a, 8'h99, 1'b0, na, wa, ea);
    model_next(m_b, 8'h59, 1'b1, nb, wb, eb);
    @(posedge clk);
    #1;
    m_a = na;
    m_b = nb;
    check("cnt_a", 32'(cnt_a), 32'(m_a));
    check("wrap_a", 32'(wrap_a), 32'(wa));
    check("ld_err_a", 32'(ld_err_a), 32'(ea));
    check("tc_a", 32'(tc_a), 32'(up ? (m_a == 8'h99) : (m_a == 8'h00)));
    check("cnt_b", 32'(cnt_b), 32'(m_b));
    check("wrap_b", 32'(wrap_b), 32'(wb));
    check("ld_err_b", 32'(ld_err_b), 32'(eb));
    check("tc_b", 32'(tc_b), 32'(up ? (m_b == 8'h59) : (m_b == 8'h00)));
  endtask

  // Pull reset low between edges and check it acts without a clock.
  task automatic async_reset();
    #3;
    rst = 1'b0;
    #1;
    check("async_cnt_a", 32'(cnt_a), 32'h00);
    check("async_cnt_b", 32'(cnt_b), 32'h00);
    check("async_wrap", 32'({wrap_a, wrap_b}), 32'h0);
    check("async_ld_err", 32'({ld_err_a, ld_err_b}), 32'h0);
    m_a = 8'h00;
    m_b = 8'h00;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    m_a = 8'h00;
    m_b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt_a", 32'(cnt_a), 32'h00);
    check("rst_cnt_b", 32'(cnt_b), 32'h00);
    check("rst_flags", 32'({wrap_a, ld_err_a, wrap_b, ld_err_b}), 32'h0);
    rst = 1'b1;

    // Count to 37 then reset asynchronously mid-cycle.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (37) tick();
    check("count_37", 32'(cnt_a), 32'h37);
    async_reset();

    // Carry chain through 99 -> 00.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h98);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    check("carry_99", 32'({cnt_a, tc_a}), 32'({8'h99, 1'b1}));
    tick();
    check("carry_00", 32'({cnt_a, wrap_a}), 32'({8'h00, 1'b1}));
    tick();
    check("carry_01", 32'({cnt_a, wrap_a}), 32'({8'h01, 1'b0}));

    // Borrow chain and down-wrap to 99.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k <= 10) check("borrow_seq", 32'(cnt_a), 32'(int2bcd(10 - k)));
      if (k == 11) check("down_wrap", 32'({cnt_a, wrap_a}), 32'({8'h99, 1'b1}));
    end

    // Saturate at 59.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h58);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    check("sat_1", 32'({cnt_b, wrap_b, tc_b}), 32'({8'h59, 1'b0, 1'b1}));
    tick();
    check("sat_2", 32'({cnt_b, wrap_b, tc_b}), 32'({8'h59, 1'b1, 1'b1}));
    tick();
    check("sat_3", 32'({cnt_b, wrap_b, tc_b}), 32'({8'h59, 1'b1, 1'b1}));

    // Load rejection against MAX_VAL=59.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h6A);
    tick();
    check("rej_6a", 32'({cnt_b, ld_err_b}), 32'({8'h59, 1'b1}));
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h60);
    tick();
    check("rej_60", 32'({cnt_b, ld_err_b}), 32'({8'h59, 1'b1}));
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h42);
    tick();
    check("acc_42", 32'({cnt_b, ld_err_b}), 32'({8'h42, 1'b0}));

    // Priority: clr > ld > en.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h25);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h33);
    tick();
    check("prio_clr", 32'({cnt_a, cnt_b}), 32'h0000);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h33);
    tick();
    check("prio_ld", 32'({cnt_a, cnt_b}), 32'h3333);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] v;
      logic       u;
      u = ($urandom_range(0, 15) == 0) ? ~up : up;
      if ($urandom_range(0, 3) == 0) v = 8'($urandom);
      else v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      drive($urandom_range(0, 3) != 0, u, $urandom_range(0, 31) == 0,
            $urandom_range(0, 15) == 0, v);
      if ($urandom_range(0, 499) == 0) async_reset();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
